// File: rtl/sensor_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sensor_monitor
// Brief    : Debounced, maskable multi-channel sensor error monitor with sticky
//            per-channel fault flags and a saturating fault-event counter.
//            Optional macro SENSOR_MON_INPUT_SYNC_EN adds a 2-flop sensor sync.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_monitor #(
  parameter int NUM_CHAN  = 4,
  parameter int DEBOUNCE  = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [4*NUM_CHAN-1:0] sensors,
  input  logic [NUM_CHAN-1:0]   chan_mask,
  input  logic                  clear,
  output logic [NUM_CHAN-1:0]   chan_error,
  output logic                  error,
  output logic [NUM_CHAN-1:0]   fault_latch,
  output logic [CNT_WIDTH-1:0]  fault_count
);

  localparam int                   DW         = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0]        C_CNT_LAST = DW'(DEBOUNCE - 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_PEND  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  logic [4*NUM_CHAN-1:0] w_sens;
  logic [NUM_CHAN-1:0]   w_fault_nxt;
  logic [NUM_CHAN-1:0]   w_entry;
  logic                  r_error;
  logic [NUM_CHAN-1:0]   r_latch;
  logic [CNT_WIDTH-1:0]  r_count;

`ifdef SENSOR_MON_INPUT_SYNC_EN
  logic [4*NUM_CHAN-1:0] r_sync1;
  logic [4*NUM_CHAN-1:0] r_sync2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sensors;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sens = r_sync2;
`else
  assign w_sens = sensors;
`endif

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] w_cnt_nxt;
    logic [3:0]    w_s;
    logic          w_raw;

    assign w_s   = w_sens[4*c +: 4];
    assign w_raw = ~chan_mask[c] & (w_s[0] | (w_s[1] & (w_s[2] | w_s[3])));

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_state <= ST_OK;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // r_cnt counts edges already seen with raw high while in PEND
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_OK: begin
          if (w_raw) begin
            if (DEBOUNCE == 1) begin
              w_state_nxt = ST_FAULT;
            end else begin
              w_state_nxt = ST_PEND;
              w_cnt_nxt   = DW'(1);
            end
          end
        end
        ST_PEND: begin
          if (!w_raw) begin
            w_state_nxt = ST_OK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_CNT_LAST) begin
            w_state_nxt = ST_FAULT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + DW'(1);
          end
        end
        ST_FAULT: begin
          if (!w_raw) begin
            w_state_nxt = ST_OK;
          end
        end
        default: begin
          w_state_nxt = ST_OK;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign w_fault_nxt[c] = (w_state_nxt == ST_FAULT);
    assign w_entry[c]     = w_fault_nxt[c] & (r_state != ST_FAULT);
    assign chan_error[c]  = (r_state == ST_FAULT);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_error <= 1'b0;
      r_latch <= '0;
      r_count <= '0;
    end else begin
      r_error <= |w_fault_nxt;
      // a new entry on the clearing edge survives the clear
      r_latch <= (clear ? {NUM_CHAN{1'b0}} : r_latch) | w_entry;
      if (clear) begin
        r_count <= (|w_entry) ? CNT_WIDTH'(1) : '0;
      end else if ((|w_entry) && (r_count != C_CNT_MAX)) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  assign error       = r_error;
  assign fault_latch = r_latch;
  assign fault_count = r_count;

endmodule
`default_nettype wire
